// File: rtl/pong_pkg.sv
// Shared types and direction encodings for the pong ball datapath.
package pong_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_MISS = 2'd2
   } ball_state_t;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;
   localparam logic DIR_UP    = 1'b0;
   localparam logic DIR_DOWN  = 1'b1;

endpackage

// File: rtl/updown_reg.sv
// Loadable up/down register; priority reset > load > inc > dec.
module updown_reg #(
   parameter int unsigned W       = 8,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset)     q <= RST_VAL;
      else if (load) q <= load_val;
      else if (inc)  q <= q + W'(1);
      else if (dec)  q <= q - W'(1);
   end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Ball motion engine: serve/run/miss FSM, tick-paced stepping, wall and paddle bounces.
// Optional speed ramp on paddle returns when BALL_SPEEDUP_EN is defined.
module ball_motion_ctrl
   import pong_pkg::*;
#(
   parameter int unsigned X_W         = 6,
   parameter int unsigned Y_W         = 5,
   parameter int unsigned X_MIN       = 1,
   parameter int unsigned X_MAX       = 62,
   parameter int unsigned Y_MIN       = 1,
   parameter int unsigned Y_MAX       = 30,
   parameter int unsigned X_START     = 8,
   parameter int unsigned Y_START     = 4,
   parameter int unsigned TICK_W      = 19,
   parameter int unsigned PERIOD_INIT = 3,
   parameter int unsigned PERIOD_MIN  = 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           enable,
   input  logic           serve,
   input  logic           hit_left,
   input  logic           hit_right,
   output logic [X_W-1:0] x_pos,
   output logic [Y_W-1:0] y_pos,
   output logic           moving_right,
   output logic           moving_down,
   output logic           step,
   output logic           miss_left,
   output logic           miss_right,
   output logic [1:0]     state
);

   localparam logic [X_W-1:0]    XMIN_V   = X_W'(X_MIN);
   localparam logic [X_W-1:0]    XMAX_V   = X_W'(X_MAX);
   localparam logic [Y_W-1:0]    YMIN_V   = Y_W'(Y_MIN);
   localparam logic [Y_W-1:0]    YMAX_V   = Y_W'(Y_MAX);
   localparam logic [X_W-1:0]    XSTART_V = X_W'(X_START);
   localparam logic [Y_W-1:0]    YSTART_V = Y_W'(Y_START);
   localparam logic [TICK_W-1:0] PINIT_V  = TICK_W'(PERIOD_INIT);

   if (!(PERIOD_MIN >= 1 && PERIOD_MIN <= PERIOD_INIT && PERIOD_INIT < 2**TICK_W)) begin : g_bad_period
      $fatal(1, "ball_motion_ctrl: illegal PERIOD_MIN/PERIOD_INIT/TICK_W");
   end
   if (!(Y_MIN < Y_MAX && Y_MIN <= Y_START && Y_START <= Y_MAX && Y_MAX < 2**Y_W)) begin : g_bad_y
      $fatal(1, "ball_motion_ctrl: illegal Y bounds");
   end
   if (!(X_MIN < X_START && X_START < X_MAX && X_MAX < 2**X_W)) begin : g_bad_x
      $fatal(1, "ball_motion_ctrl: illegal X bounds");
   end

   ball_state_t       r_state, w_state_nxt;
   logic [TICK_W-1:0] r_tick, w_period;
   logic              r_right, r_down, r_step, r_miss_l, r_miss_r;
   logic [X_W-1:0]    w_x;
   logic [Y_W-1:0]    w_y;
   logic              w_step_cyc, w_at_left, w_at_right, w_miss_l, w_miss_r;
   logic              w_move, w_ret, w_serve_ld, w_right_nxt, w_down_nxt;

   // Step decisions are taken on pre-step position and direction.
   always_comb begin
      w_state_nxt = r_state;
      w_serve_ld  = 1'b0;
      w_step_cyc  = (r_state == ST_RUN) && enable && (r_tick == w_period - TICK_W'(1));
      w_at_left   = (r_right == DIR_LEFT)  && (w_x <= XMIN_V);
      w_at_right  = (r_right == DIR_RIGHT) && (w_x >= XMAX_V);
      w_miss_l    = w_step_cyc && w_at_left  && !hit_left;
      w_miss_r    = w_step_cyc && w_at_right && !hit_right;
      w_move      = w_step_cyc && !w_miss_l && !w_miss_r;
      w_ret       = w_move && (w_at_left || w_at_right);
      w_right_nxt = r_right;
      if (w_at_left)       w_right_nxt = DIR_RIGHT;
      else if (w_at_right) w_right_nxt = DIR_LEFT;
      w_down_nxt = r_down;
      if (w_y <= YMIN_V)      w_down_nxt = DIR_DOWN;
      else if (w_y >= YMAX_V) w_down_nxt = DIR_UP;

      case (r_state)
         ST_IDLE, ST_MISS: begin
            if (serve) begin
               w_state_nxt = ST_RUN;
               w_serve_ld  = 1'b1;
            end
         end
         ST_RUN: begin
            if (w_miss_l || w_miss_r) w_state_nxt = ST_MISS;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tick   <= '0;
         r_right  <= DIR_LEFT;
         r_down   <= DIR_DOWN;
         r_step   <= 1'b0;
         r_miss_l <= 1'b0;
         r_miss_r <= 1'b0;
      end else begin
         r_step   <= w_step_cyc;
         r_miss_l <= w_miss_l;
         r_miss_r <= w_miss_r;
         if (w_serve_ld) begin
            r_tick <= '0;
            r_down <= DIR_DOWN;
         end else if (w_step_cyc) begin
            r_tick <= '0;
            if (w_move) begin
               r_down  <= w_down_nxt;
               r_right <= w_right_nxt;
            end
         end else if (r_state == ST_RUN && enable) begin
            r_tick <= r_tick + TICK_W'(1);
         end
      end
   end

`ifdef BALL_SPEEDUP_EN
   localparam logic [TICK_W-1:0] PMIN_V = TICK_W'(PERIOD_MIN);
   logic [TICK_W-1:0] r_period;

   // Each return shortens the step period down to the floor.
   always_ff @(posedge clk) begin
      if (reset || w_serve_ld)           r_period <= PINIT_V;
      else if (w_ret && r_period > PMIN_V) r_period <= r_period - TICK_W'(1);
   end
   assign w_period = r_period;
`else
   assign w_period = PINIT_V;
`endif

   updown_reg #(.W(X_W), .RST_VAL(XSTART_V)) u_x (
      .clk      (clk),
      .reset    (reset),
      .load     (w_serve_ld),
      .load_val (XSTART_V),
      .inc      (w_move && (w_right_nxt == DIR_RIGHT)),
      .dec      (w_move && (w_right_nxt == DIR_LEFT)),
      .q        (w_x)
   );

   updown_reg #(.W(Y_W), .RST_VAL(YSTART_V)) u_y (
      .clk      (clk),
      .reset    (reset),
      .load     (w_serve_ld),
      .load_val (YSTART_V),
      .inc      (w_move && (w_down_nxt == DIR_DOWN)),
      .dec      (w_move && (w_down_nxt == DIR_UP)),
      .q        (w_y)
   );

   assign x_pos        = w_x;
   assign y_pos        = w_y;
   assign moving_right = r_right;
   assign moving_down  = r_down;
   assign step         = r_step;
   assign miss_left    = r_miss_l;
   assign miss_right   = r_miss_r;
   assign state        = r_state;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Bench for ball_motion_ctrl: vector table, hand sequences, randomized run against a model.
module tb_ball_motion_ctrl;

   localparam int XS = 8, YS = 4, XLO = 1, XHI = 62, YLO = 1, YHI = 30, PINIT = 3, PMIN = 1;
`ifdef BALL_SPEEDUP_EN
   localparam int SPACE_RET = 2;
`else
   localparam int SPACE_RET = 3;
`endif

   logic       clk = 1'b0;
   logic       reset, enable, serve, hit_left, hit_right;
   logic [5:0] x_pos;
   logic [4:0] y_pos;
   logic       moving_right, moving_down, step, miss_left, miss_right;
   logic [1:0] state;

   int n_cmp = 0;
   int n_bad = 0;

   ball_motion_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .serve        (serve),
      .hit_left     (hit_left),
      .hit_right    (hit_right),
      .x_pos        (x_pos),
      .y_pos        (y_pos),
      .moving_right (moving_right),
      .moving_down  (moving_down),
      .step         (step),
      .miss_left    (miss_left),
      .miss_right   (miss_right),
      .state        (state)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Returns edges elapsed until step is seen, or -1 if it never comes.
   task automatic wait_step(output int n);
      n = 0;
      repeat (20) begin
         cyc();
         n++;
         if (step) return;
      end
      n = -1;
   endtask

   typedef struct {
      logic rst, en, srv, hl, hr;
      int   x, y;
      logic r, d, st, ml, mr;
      int   s;
   } vec_t;

   // Behavioural reference model.
   int m_x, m_y, m_r, m_d, m_per, m_tick, m_st, m_step, m_ml, m_mr;

   task automatic model_edge(input logic rst, input logic en, input logic srv,
                             input logic hl, input logic hr);
      if (rst) begin
         m_x = XS; m_y = YS; m_r = 0; m_d = 1; m_per = PINIT; m_tick = 0;
         m_st = 0; m_step = 0; m_ml = 0; m_mr = 0;
         return;
      end
      m_step = 0; m_ml = 0; m_mr = 0;
      if (m_st != 1) begin
         if (srv) begin
            m_x = XS; m_y = YS; m_d = 1; m_per = PINIT; m_tick = 0; m_st = 1;
         end
      end else if (en) begin
         if (m_tick < m_per - 1) begin
            m_tick++;
         end else begin
            m_tick = 0;
            m_step = 1;
            if (m_r == 0 && m_x <= XLO && !hl) begin
               m_ml = 1; m_st = 2;
            end else if (m_r == 1 && m_x >= XHI && !hr) begin
               m_mr = 1; m_st = 2;
            end else begin
               if ((m_r == 0 && m_x <= XLO) || (m_r == 1 && m_x >= XHI)) begin
                  m_r = 1 - m_r;
`ifdef BALL_SPEEDUP_EN
                  m_per = (m_per - 1 > PMIN) ? m_per - 1 : PMIN;
`endif
               end
               if (m_y <= YLO)      m_d = 1;
               else if (m_y >= YHI) m_d = 0;
               m_y += m_d ? 1 : -1;
               m_x += m_r ? 1 : -1;
            end
         end
      end
   endtask

   initial begin
      vec_t tbl[12];
      int   n, cnt;
      logic [17:0] act, exp;

      reset = 1'b1; enable = 1'b1; serve = 1'b0; hit_left = 1'b0; hit_right = 1'b0;

      //          rst en srv hl hr  x  y  r  d  st ml mr s
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8, 4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8, 4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
      tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8, 4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8, 4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8, 4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7, 5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7, 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7, 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7, 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7, 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6, 6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
      tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8, 4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};

      for (int i = 0; i < 12; i++) begin
         reset = tbl[i].rst; enable = tbl[i].en; serve = tbl[i].srv;
         hit_left = tbl[i].hl; hit_right = tbl[i].hr;
         cyc();
         act = {x_pos, y_pos, moving_right, moving_down, step, miss_left, miss_right, state};
         exp = {6'(tbl[i].x), 5'(tbl[i].y), tbl[i].r, tbl[i].d, tbl[i].st,
                tbl[i].ml, tbl[i].mr, 2'(tbl[i].s)};
         n_cmp++;
         if (act !== exp) begin
            n_bad++;
            $display("FAIL vec%0d: got x=%0d y=%0d r=%0b d=%0b st=%0b ml=%0b mr=%0b s=%0d expected x=%0d y=%0d r=%0b d=%0b st=%0b ml=%0b mr=%0b s=%0d",
                     i, x_pos, y_pos, moving_right, moving_down, step, miss_left, miss_right, state,
                     tbl[i].x, tbl[i].y, tbl[i].r, tbl[i].d, tbl[i].st, tbl[i].ml, tbl[i].mr, tbl[i].s);
         end
      end

      // Full rally: left return, bottom and top bounces, right miss.
      reset = 1'b0; enable = 1'b1; hit_left = 1'b1; hit_right = 1'b0; serve = 1'b1;
      cyc();
      serve = 1'b0;
      chk("serve_state", int'(state), 1);
      for (int k = 1; k <= 69; k++) begin
         wait_step(n);
         if (n < 0) begin
            chk("step_timeout", n, 0);
            break;
         end
         if (k == 1) begin
            chk("space_first", n, 3);
            chk("k1_x", int'(x_pos), 7);
            chk("k1_y", int'(y_pos), 5);
         end
         if (k == 8) begin
            chk("ret_x", int'(x_pos), 2);
            chk("ret_dir", int'(moving_right), 1);
         end
         if (k == 9)  chk("space_after_ret", n, SPACE_RET);
         if (k == 10) chk("space_after_ret2", n, SPACE_RET);
         if (k == 26) chk("bot_y", int'(y_pos), 30);
         if (k == 27) begin
            chk("bounce_y", int'(y_pos), 29);
            chk("bounce_dir", int'(moving_down), 0);
         end
         if (k == 56) begin
            chk("top_y", int'(y_pos), 2);
            chk("top_dir", int'(moving_down), 1);
         end
         if (k == 69) begin
            chk("miss_r_pulse", int'(miss_right), 1);
            chk("miss_l_quiet", int'(miss_left), 0);
            chk("miss_state", int'(state), 2);
            chk("miss_x", int'(x_pos), 62);
            chk("miss_y", int'(y_pos), 14);
         end
      end

      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (i == 0) chk("miss_one_cycle", int'(miss_right), 0);
         if (step) cnt++;
      end
      chk("no_step_in_miss", cnt, 0);
      chk("miss_hold_x", int'(x_pos), 62);

      serve = 1'b1;
      cyc();
      serve = 1'b0;
      chk("reserve_x", int'(x_pos), 8);
      chk("reserve_y", int'(y_pos), 4);
      chk("reserve_dir", int'(moving_right), 1);
      chk("reserve_state", int'(state), 1);
      wait_step(n);
      chk("reserve_space", n, 3);
      chk("reserve_step_x", int'(x_pos), 9);

      serve = 1'b1;
      cyc();
      serve = 1'b0;
      chk("serve_in_run_state", int'(state), 1);
      chk("serve_in_run_x", int'(x_pos), 9);

      enable = 1'b0;
      cnt = 0;
      repeat (10) begin
         cyc();
         if (step) cnt++;
      end
      chk("pause_no_step", cnt, 0);
      enable = 1'b1;
      wait_step(n);
      chk("pause_tick_held", n, 2);
      chk("pause_resume_x", int'(x_pos), 10);

      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("rst_state", int'(state), 0);
      chk("rst_x", int'(x_pos), 8);
      chk("rst_y", int'(y_pos), 4);
      chk("rst_pulses", int'({step, miss_left, miss_right}), 0);

      // Randomized run against the reference model.
      for (int i = 0; i < 5000; i++) begin
         reset     = (i == 0) || ($urandom_range(0, 599) == 0);
         serve     = ($urandom_range(0, 15) == 0);
         enable    = ($urandom_range(0, 7) != 0);
         hit_left  = ($urandom_range(0, 3) != 0);
         hit_right = ($urandom_range(0, 3) != 0);
         model_edge(reset, enable, serve, hit_left, hit_right);
         cyc();
         act = {x_pos, y_pos, moving_right, moving_down, step, miss_left, miss_right, state};
         exp = {6'(m_x), 5'(m_y), 1'(m_r), 1'(m_d), 1'(m_step), 1'(m_ml), 1'(m_mr), 2'(m_st)};
         n_cmp++;
         if (act !== exp) begin
            n_bad++;
            $display("FAIL rand cycle %0d: got %h expected %h", i, act, exp);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
